idma_mc_job_sched: RTL and testbench

- Multi-channel job scheduler for the iDMA subsystem. It sits between N register frontends and one shared iDMA backend.
- Each channel owns a job FIFO and its own transfer-ID counters (next/done).
- A round-robin arbiter feeds a registered backend request slot. An in-order retire FIFO maps backend responses back to the issuing channel.
- Generalises the single-stream frontend→FIFO→backend path of the Cheshire wrapper to NumChannels streams, with an outstanding-job limit.

---
 rtl/idma_mc_job_sched.sv | 176 +++++++++++++++++
 tb/tb_idma_mc_job_sched.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idma_mc_job_sched.sv
// Multi-channel iDMA job scheduler: per-channel job FIFOs and transfer-ID counters,
// round-robin grant into a registered backend slot, in-order retire FIFO for responses.
// Optional macro IDMA_MC_PRIO_EN adds ch_prio_i to favour prioritised channels.
module idma_mc_job_sched #(
  parameter int unsigned NumChannels    = 4,
  parameter int unsigned JobWidth       = 128,
  parameter int unsigned FifoDepth      = 4,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned IdWidth        = 32,
  parameter int unsigned ChIdxWidth     = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumChannels*JobWidth-1:0] ch_req_i,
  input  logic [NumChannels-1:0]          ch_valid_i,
`ifdef IDMA_MC_PRIO_EN
  input  logic [NumChannels-1:0]          ch_prio_i,
`endif
  output logic [NumChannels-1:0]          ch_ready_o,
  output logic [NumChannels*IdWidth-1:0]  ch_next_id_o,
  output logic [NumChannels*IdWidth-1:0]  ch_done_id_o,
  output logic [NumChannels-1:0]          ch_busy_o,
  output logic [JobWidth-1:0]             be_req_o,
  output logic [ChIdxWidth-1:0]           be_chan_o,
  output logic                            be_valid_o,
  input  logic                            be_ready_i,
  input  logic                            be_rsp_valid_i,
  output logic                            be_rsp_ready_o
);

  localparam int unsigned FifoPtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned FifoCntW = $clog2(FifoDepth + 1);
  localparam int unsigned RetPtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned RetCntW  = $clog2(MaxOutstanding + 1);
  localparam int unsigned InflW    = RetCntW + 1;

  typedef logic [JobWidth-1:0]   job_t;
  typedef logic [ChIdxWidth-1:0] chan_t;
  typedef logic [IdWidth-1:0]    id_t;

  job_t                fifo_mem_q [NumChannels][FifoDepth];
  logic [FifoPtrW-1:0] fifo_wr_q  [NumChannels];
  logic [FifoPtrW-1:0] fifo_rd_q  [NumChannels];
  logic [FifoCntW-1:0] fifo_cnt_q [NumChannels];
  id_t                 next_id_q  [NumChannels];
  id_t                 done_id_q  [NumChannels];

  chan_t               ret_mem_q [MaxOutstanding];
  logic [RetPtrW-1:0]  ret_wr_q, ret_rd_q;
  logic [RetCntW-1:0]  ret_cnt_q;

  job_t  be_req_q;
  chan_t be_chan_q;
  logic  be_valid_q;
  chan_t rr_q;

  logic [NumChannels-1:0] fifo_nonempty, fifo_full, ch_push, ch_pop, ch_retire, cand;
  logic                   any_cand, be_slot_free, room, grant, be_hs, rsp_pop;
  logic [InflW-1:0]       inflight;
  chan_t                  grant_idx, ret_head;

  function automatic logic [FifoPtrW-1:0] fifo_ptr_inc(input logic [FifoPtrW-1:0] p);
    return (p == FifoPtrW'(FifoDepth - 1)) ? '0 : p + FifoPtrW'(1);
  endfunction

  function automatic logic [RetPtrW-1:0] ret_ptr_inc(input logic [RetPtrW-1:0] p);
    return (p == RetPtrW'(MaxOutstanding - 1)) ? '0 : p + RetPtrW'(1);
  endfunction

  // First candidate at or after 'start', wrapping around the channel ring.
  function automatic chan_t rr_pick(input logic [NumChannels-1:0] c_vec, input chan_t start);
    chan_t pick;
    chan_t pos;
    logic  found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NumChannels; i++) begin
      pos = chan_t'((32'(start) + i) % NumChannels);
      if (!found && c_vec[pos]) begin
        found = 1'b1;
        pick  = pos;
      end
    end
    return pick;
  endfunction

  always_comb begin
    for (int c = 0; c < NumChannels; c++) begin
      fifo_nonempty[c] = (fifo_cnt_q[c] != '0);
      fifo_full[c]     = (fifo_cnt_q[c] == FifoCntW'(FifoDepth));
    end
  end

  // Ready looks only at registered occupancy, so a full FIFO never accepts even while popping.
  assign ch_ready_o = ~fifo_full & {NumChannels{~rst_i}};
  assign ch_push    = ch_valid_i & ch_ready_o;

`ifdef IDMA_MC_PRIO_EN
  assign cand = ((fifo_nonempty & ch_prio_i) != '0) ? (fifo_nonempty & ch_prio_i) : fifo_nonempty;
`else
  assign cand = fifo_nonempty;
`endif

  assign any_cand       = |cand;
  assign grant_idx      = rr_pick(cand, rr_q);
  assign be_hs          = be_valid_q & be_ready_i;
  assign ret_head       = ret_mem_q[ret_rd_q];
  assign be_rsp_ready_o = (ret_cnt_q != '0) & ~rst_i;
  assign rsp_pop        = be_rsp_valid_i & be_rsp_ready_o;
  assign inflight       = InflW'(ret_cnt_q) + InflW'(be_valid_q);
  assign room           = (inflight - InflW'(rsp_pop)) < InflW'(MaxOutstanding);
  assign be_slot_free   = ~be_valid_q | be_ready_i;
  assign grant          = be_slot_free & any_cand & room & ~rst_i;
  assign ch_pop         = grant   ? (NumChannels'(1) << grant_idx) : '0;
  assign ch_retire      = rsp_pop ? (NumChannels'(1) << ret_head)  : '0;

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < NumChannels; c++) begin
        fifo_wr_q[c]  <= '0;
        fifo_rd_q[c]  <= '0;
        fifo_cnt_q[c] <= '0;
        next_id_q[c]  <= id_t'(1);
        done_id_q[c]  <= '0;
      end
      ret_wr_q   <= '0;
      ret_rd_q   <= '0;
      ret_cnt_q  <= '0;
      be_req_q   <= '0;
      be_chan_q  <= '0;
      be_valid_q <= 1'b0;
      rr_q       <= '0;
    end else begin
      for (int c = 0; c < NumChannels; c++) begin
        if (ch_push[c]) fifo_wr_q[c] <= fifo_ptr_inc(fifo_wr_q[c]);
        if (ch_pop[c])  fifo_rd_q[c] <= fifo_ptr_inc(fifo_rd_q[c]);
        fifo_cnt_q[c] <= fifo_cnt_q[c] + FifoCntW'(ch_push[c]) - FifoCntW'(ch_pop[c]);
        next_id_q[c]  <= next_id_q[c] + id_t'(ch_push[c]);
        done_id_q[c]  <= done_id_q[c] + id_t'(ch_retire[c]);
      end
      if (be_hs)   ret_wr_q <= ret_ptr_inc(ret_wr_q);
      if (rsp_pop) ret_rd_q <= ret_ptr_inc(ret_rd_q);
      ret_cnt_q <= ret_cnt_q + RetCntW'(be_hs) - RetCntW'(rsp_pop);
      if (grant) begin
        be_req_q   <= fifo_mem_q[grant_idx][fifo_rd_q[grant_idx]];
        be_chan_q  <= grant_idx;
        be_valid_q <= 1'b1;
        rr_q       <= chan_t'((32'(grant_idx) + 32'd1) % NumChannels);
      end else if (be_hs) begin
        be_valid_q <= 1'b0;
      end
    end
  end

  // NOTE: storage arrays carry no reset; the occupancy counters alone decide which entries are live.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NumChannels; c++) begin
      if (ch_push[c]) fifo_mem_q[c][fifo_wr_q[c]] <= ch_req_i[c*JobWidth +: JobWidth];
    end
    if (be_hs) ret_mem_q[ret_wr_q] <= be_chan_q;
  end

  always_comb begin
    for (int c = 0; c < NumChannels; c++) begin
      ch_next_id_o[c*IdWidth +: IdWidth] = next_id_q[c];
      ch_done_id_o[c*IdWidth +: IdWidth] = done_id_q[c];
      ch_busy_o[c] = fifo_nonempty[c] | ((next_id_q[c] - done_id_q[c]) != id_t'(1));
    end
  end

  assign be_req_o   = be_req_q;
  assign be_chan_o  = be_chan_q;
  assign be_valid_o = be_valid_q;

endmodule

// File: tb/tb_idma_mc_job_sched.sv
// Self-checking bench for idma_mc_job_sched: queue-based reference model plus a handshake
// scoreboard, directed scenarios followed by randomized traffic. IdWidth=4 exercises ID wrap.
module tb_idma_mc_job_sched;

  localparam int NCH   = 4;
  localparam int JW    = 128;
  localparam int FDEPTH = 4;
  localparam int MAXO  = 8;
  localparam int IW    = 4;
  localparam int IDMOD = 16;
  localparam int CW    = 2;

  logic                clk = 1'b0;
  logic                rst_i;
  logic [NCH*JW-1:0]   ch_req_i;
  logic [NCH-1:0]      ch_valid_i;
  logic [NCH-1:0]      ch_ready_o;
  logic [NCH*IW-1:0]   ch_next_id_o;
  logic [NCH*IW-1:0]   ch_done_id_o;
  logic [NCH-1:0]      ch_busy_o;
  logic [JW-1:0]       be_req_o;
  logic [CW-1:0]       be_chan_o;
  logic                be_valid_o;
  logic                be_ready_i;
  logic                be_rsp_valid_i;
  logic                be_rsp_ready_o;
`ifdef IDMA_MC_PRIO_EN
  logic [NCH-1:0]      ch_prio;
`endif

  idma_mc_job_sched #(
    .NumChannels(NCH), .JobWidth(JW), .FifoDepth(FDEPTH),
    .MaxOutstanding(MAXO), .IdWidth(IW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .ch_req_i       (ch_req_i),
    .ch_valid_i     (ch_valid_i),
`ifdef IDMA_MC_PRIO_EN
    .ch_prio_i      (ch_prio),
`endif
    .ch_ready_o     (ch_ready_o),
    .ch_next_id_o   (ch_next_id_o),
    .ch_done_id_o   (ch_done_id_o),
    .ch_busy_o      (ch_busy_o),
    .be_req_o       (be_req_o),
    .be_chan_o      (be_chan_o),
    .be_valid_o     (be_valid_o),
    .be_ready_i     (be_ready_i),
    .be_rsp_valid_i (be_rsp_valid_i),
    .be_rsp_ready_o (be_rsp_ready_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [JW-1:0] act, input logic [JW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-channel job queues, retire queue, ID counters as plain integers.
  typedef struct packed { logic [JW-1:0] job; logic [7:0] chan; } exp_t;
  exp_t          exp_q[$];
  logic [JW-1:0] mq [NCH][$];
  int            ret_q[$];
  int            m_next[NCH], m_done[NCH], acc_cnt[NCH];
  int            m_rr, m_chan, m_k, m_infl, m_r;
  bit            m_valid, m_init, m_hs, m_pop, m_grant;
  logic [NCH-1:0]    m_acc, m_cand, exp_rdy, exp_busy;
  logic [NCH*IW-1:0] exp_next, exp_done;
  exp_t          m_e;

  initial for (int c = 0; c < NCH; c++) acc_cnt[c] = 0;

  always @(negedge clk) begin
    if (m_init) begin
      for (int c = 0; c < NCH; c++) begin
        exp_rdy[c]  = !rst_i && (mq[c].size() < FDEPTH);
        exp_next[c*IW +: IW] = IW'(m_next[c]);
        exp_done[c*IW +: IW] = IW'(m_done[c]);
        exp_busy[c] = (mq[c].size() > 0) || (((m_next[c] - m_done[c] + IDMOD) % IDMOD) != 1);
      end
      check("ch_ready_o", ch_ready_o, exp_rdy);
      check("ch_next_id_o", ch_next_id_o, exp_next);
      check("ch_done_id_o", ch_done_id_o, exp_done);
      check("ch_busy_o", ch_busy_o, exp_busy);
      check("be_valid_o", be_valid_o, m_valid);
      check("be_rsp_ready_o", be_rsp_ready_o, !rst_i && ret_q.size() > 0);
    end
    if (rst_i) begin
      for (int c = 0; c < NCH; c++) begin
        mq[c].delete();
        m_next[c] = 1;
        m_done[c] = 0;
      end
      ret_q.delete();
      exp_q.delete();
      m_rr = 0; m_chan = 0; m_valid = 0; m_init = 1;
    end else if (m_init) begin
      m_hs   = m_valid && be_ready_i;
      m_pop  = be_rsp_valid_i && ret_q.size() > 0;
      m_infl = ret_q.size() + int'(m_valid);
      for (int c = 0; c < NCH; c++) begin
        m_acc[c]  = ch_valid_i[c] && (mq[c].size() < FDEPTH);
        m_cand[c] = mq[c].size() > 0;
      end
`ifdef IDMA_MC_PRIO_EN
      if ((m_cand & ch_prio) != '0) m_cand = m_cand & ch_prio;
`endif
      m_k = -1;
      for (int i = 0; i < NCH; i++)
        if (m_k < 0 && m_cand[(m_rr + i) % NCH]) m_k = (m_rr + i) % NCH;
      m_grant = (!m_valid || be_ready_i) && m_k >= 0 && (m_infl - int'(m_pop)) < MAXO;
      if (m_pop) begin
        m_r = ret_q.pop_front();
        m_done[m_r] = (m_done[m_r] + 1) % IDMOD;
      end
      if (m_hs) ret_q.push_back(m_chan);
      if (m_grant) begin
        m_e.job  = mq[m_k].pop_front();
        m_e.chan = 8'(m_k);
        exp_q.push_back(m_e);
        m_chan  = m_k;
        m_valid = 1;
        m_rr    = (m_k + 1) % NCH;
      end else if (m_hs) begin
        m_valid = 0;
      end
      for (int c = 0; c < NCH; c++) begin
        if (m_acc[c]) begin
          mq[c].push_back(ch_req_i[c*JW +: JW]);
          m_next[c] = (m_next[c] + 1) % IDMOD;
          acc_cnt[c]++;
        end
      end
    end
  end

  // Monitor: compares each backend handshake against the scoreboard and checks output hold.
  int            hs_count = 0;
  int            hs_chans[$];
  bit            prev_hold = 0;
  logic [JW-1:0] prev_req;
  logic [CW-1:0] prev_chan;
  exp_t          mon_e;

  always @(negedge clk) begin
    if (m_init && !rst_i) begin
      if (prev_hold && be_valid_o) begin
        check("hold_be_req_o", be_req_o, prev_req);
        check("hold_be_chan_o", be_chan_o, prev_chan);
      end
      if (be_valid_o && be_ready_i) begin
        hs_count++;
        hs_chans.push_back(int'(be_chan_o));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL be_handshake actual=unexpected chan %0d expected=no request at %0t", be_chan_o, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("be_req_o", be_req_o, mon_e.job);
          check("be_chan_o", be_chan_o, mon_e.chan);
        end
      end
      prev_hold = be_valid_o && !be_ready_i;
      prev_req  = be_req_o;
      prev_chan = be_chan_o;
    end else begin
      prev_hold = 0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_req();
    for (int c = 0; c < NCH; c++) ch_req_i[c*JW +: JW] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  int base, base_hs, d0, n1;

  initial begin
    rst_i = 1; ch_valid_i = '0; be_ready_i = 0; be_rsp_valid_i = 0;
    rand_req();
`ifdef IDMA_MC_PRIO_EN
    ch_prio = '0;
`endif
    cyc(2);
    rst_i = 0;
    cyc(3);
    check("idle ch_ready_o", ch_ready_o, 4'b1111);
    check("idle ch_busy_o", ch_busy_o, 4'b0000);

    // One job per channel in the same cycle; grants must walk 0,1,2,3.
    hs_chans.delete();
    rand_req(); ch_valid_i = 4'hF; be_ready_i = 1; be_rsp_valid_i = 1;
    cyc(1);
    ch_valid_i = '0;
    cyc(10);
    for (int i = 0; i < 4; i++) begin
      if (i < hs_chans.size()) check("rr_order", hs_chans[i], i);
      else check("rr_order_count", hs_chans.size(), 4);
    end
    check("A next_id", ch_next_id_o, {4{4'd2}});
    check("A done_id", ch_done_id_o, {4{4'd1}});
    check("A busy", ch_busy_o, 4'b0000);

    // Backpressure on ch2: slot holds one job, FIFO takes FifoDepth more.
    be_ready_i = 0;
    base = acc_cnt[2];
    for (int i = 0; i < 8; i++) begin
      rand_req(); ch_valid_i = 4'b0100;
      cyc(1);
    end
    ch_valid_i = '0;
    check("B accepted", acc_cnt[2] - base, 1 + FDEPTH);
    check("B ready2", ch_ready_o[2], 1'b0);
    check("B chan", be_chan_o, 2'd2);
    be_ready_i = 1;
    cyc(15);

    // Outstanding limit with no responses.
    be_rsp_valid_i = 0;
    base = acc_cnt[0];
    base_hs = hs_count;
    for (int i = 0; i < 40; i++) begin
      rand_req();
      ch_valid_i = (acc_cnt[0] - base < 12) ? 4'b0001 : 4'b0000;
      cyc(1);
    end
    ch_valid_i = '0;
    check("C handshakes", hs_count - base_hs, MAXO);
    check("C be_valid", be_valid_o, 1'b0);
    d0 = m_done[0];
    be_rsp_valid_i = 1;
    cyc(1);
    be_rsp_valid_i = 0;
    cyc(2);
    check("C regrant", hs_count - base_hs, MAXO + 1);
    check("C done0", ch_done_id_o[IW-1:0], IW'((d0 + 1) % IDMOD));
    be_rsp_valid_i = 1;
    cyc(30);

    // ID wrap on ch1: 16 accept/retire pairs.
    base = acc_cnt[1];
    n1 = m_next[1];
    for (int i = 0; i < 100; i++) begin
      rand_req();
      ch_valid_i = (acc_cnt[1] - base < 16) ? 4'b0010 : 4'b0000;
      cyc(1);
    end
    ch_valid_i = '0;
    cyc(10);
    check("D next1", ch_next_id_o[IW +: IW], IW'((n1 + 16) % IDMOD));
    check("D busy", ch_busy_o, 4'b0000);

    // Mid-operation reset with three outstanding jobs.
    be_rsp_valid_i = 0;
    rand_req(); ch_valid_i = 4'b0111;
    cyc(1);
    ch_valid_i = '0;
    cyc(6);
    check("E rsp_ready before", be_rsp_ready_o, 1'b1);
    rst_i = 1;
    cyc(1);
    rst_i = 0;
    be_rsp_valid_i = 1;
    cyc(1);
    check("E rsp_ready after", be_rsp_ready_o, 1'b0);
    check("E done_id", ch_done_id_o, '0);
    check("E next_id", ch_next_id_o, {4{4'd1}});
    hs_chans.delete();
    rand_req(); ch_valid_i = 4'b1000;
    cyc(1);
    ch_valid_i = '0;
    cyc(4);
    check("E regrant count", hs_chans.size(), 1);
    if (hs_chans.size() > 0) check("E regrant chan", hs_chans[0], 3);

`ifdef IDMA_MC_PRIO_EN
    hs_chans.delete();
    ch_prio = 4'b1000;
    rand_req(); ch_valid_i = 4'hF;
    cyc(1);
    ch_valid_i = '0;
    cyc(8);
    if (hs_chans.size() > 0) check("prio first", hs_chans[0], 3);
    else check("prio count", hs_chans.size(), 4);
    ch_prio = '0;
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rand_req();
      ch_valid_i     = NCH'($urandom);
      be_ready_i     = ($urandom_range(0, 3) != 0);
      be_rsp_valid_i = 1'($urandom_range(0, 1));
      rst_i          = ($urandom_range(0, 999) == 0);
`ifdef IDMA_MC_PRIO_EN
      ch_prio        = NCH'($urandom);
`endif
      cyc(1);
    end
    rst_i = 0; ch_valid_i = '0; be_ready_i = 1; be_rsp_valid_i = 1;
    cyc(40);
    check("final busy", ch_busy_o, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
